// File: rtl/fft_band_eq.sv
`default_nettype none
// ============================================================================
// Module   : fft_band_eq
// Purpose  : Per-band spectral equalizer between forward-FFT source and
//            inverse-FFT sink; mirrored band lookup, Q4.4 gain, saturation.
// Revision : 1.0 - initial release
// ============================================================================
module fft_band_eq #(
  parameter int POINTS = 4096,
  parameter int BANDS  = 8,
  parameter int GAIN_W = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_sop,
  input  logic                       in_eop,
  input  logic signed [15:0]         in_real,
  input  logic signed [15:0]         in_imag,
  input  logic signed [5:0]          in_exp,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_sop,
  output logic                       out_eop,
  output logic signed [15:0]         out_real,
  output logic signed [15:0]         out_imag,
  output logic signed [5:0]          out_exp,
  input  logic                       gain_we,
  input  logic [$clog2(BANDS)-1:0]   gain_addr,
  input  logic [GAIN_W-1:0]          gain_wdata,
  output logic                       frame_err
);

  localparam int c_CNT_W  = $clog2(POINTS);
  localparam int c_BAND_W = $clog2(BANDS);
  localparam int c_SHIFT  = $clog2(POINTS / 2) - c_BAND_W;
  localparam int c_PROD_W = 16 + GAIN_W + 1;
  localparam int c_FRAC   = 4;
  localparam int c_RES_W  = c_PROD_W - c_FRAC;

  localparam logic [c_CNT_W-1:0]        c_ZERO     = '0;
  localparam logic [c_CNT_W-1:0]        c_ONE      = c_CNT_W'(1);
  localparam logic [c_CNT_W-1:0]        c_HALF     = c_CNT_W'(POINTS / 2);
  localparam logic [c_CNT_W-1:0]        c_LAST     = c_CNT_W'(POINTS - 1);
  localparam logic [c_CNT_W-1:0]        c_BAND_TOP = c_CNT_W'(BANDS - 1);
  localparam logic [c_BAND_W-1:0]       c_BAND_MAX = c_BAND_W'(BANDS - 1);
  localparam logic [GAIN_W-1:0]         c_GAIN_RST = GAIN_W'(16);
  localparam logic signed [c_RES_W-1:0] c_SAT_MAX  = c_RES_W'(32767);
  localparam logic signed [c_RES_W-1:0] c_SAT_MIN  = c_RES_W'(-32768);

  logic                       w_en;
  logic                       w_accept;
  logic [c_CNT_W-1:0]         w_bin;
  logic [c_CNT_W-1:0]         w_mirror;
  logic [c_CNT_W-1:0]         w_band_raw;
  logic [c_BAND_W-1:0]        w_band;
  logic [GAIN_W-1:0]          w_gain;
  logic signed [GAIN_W:0]     w_gain_s;
  logic signed [c_PROD_W-1:0] w_prod_re;
  logic signed [c_PROD_W-1:0] w_prod_im;

  logic [c_CNT_W-1:0]         r_bin;
  logic [GAIN_W-1:0]          r_live   [BANDS];
  logic [GAIN_W-1:0]          r_shadow [BANDS];
  logic                       r_frame_err;

  logic                       r1_valid;
  logic                       r1_sop;
  logic                       r1_eop;
  logic signed [5:0]          r1_exp;
  logic signed [c_PROD_W-1:0] r1_prod_re;
  logic signed [c_PROD_W-1:0] r1_prod_im;

  assign w_en      = !out_valid || out_ready;
  assign in_ready  = w_en;
  assign w_accept  = in_valid && w_en;
  assign frame_err = r_frame_err;

  // A sop beat is bin 0 regardless of where the counter stands.
  assign w_bin      = in_sop ? c_ZERO : r_bin;
  assign w_mirror   = (w_bin <= c_HALF) ? w_bin : (c_ZERO - w_bin);
  assign w_band_raw = w_mirror >> c_SHIFT;
  assign w_band     = (w_band_raw > c_BAND_TOP) ? c_BAND_MAX : w_band_raw[c_BAND_W-1:0];

  // The sop beat already belongs to the new frame, whose shadow is loaded
  // from the live file on this very edge.
  assign w_gain    = in_sop ? r_live[w_band] : r_shadow[w_band];
  assign w_gain_s  = {1'b0, w_gain};
  assign w_prod_re = in_real * w_gain_s;
  assign w_prod_im = in_imag * w_gain_s;

  function automatic logic signed [15:0] sat16(input logic signed [c_PROD_W-1:0] p);
    logic signed [c_RES_W-1:0] r;
    r = p[c_PROD_W-1:c_FRAC];
    if (r > c_SAT_MAX)      return 16'sh7FFF;
    else if (r < c_SAT_MIN) return 16'sh8000;
    else                    return r[15:0];
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < BANDS; i++) begin
        r_live[i]   <= c_GAIN_RST;
        r_shadow[i] <= c_GAIN_RST;
      end
    end else begin
      if (gain_we) r_live[gain_addr] <= gain_wdata;
      if (w_accept && in_sop) r_shadow <= r_live;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bin       <= c_ZERO;
      r_frame_err <= 1'b0;
    end else if (w_accept) begin
      r_bin <= w_bin + c_ONE;
      if (in_eop && (w_bin != c_LAST)) r_frame_err <= 1'b1;
    end
  end

  // Stage 1: lookup and multiply.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r1_valid   <= 1'b0;
      r1_sop     <= 1'b0;
      r1_eop     <= 1'b0;
      r1_exp     <= '0;
      r1_prod_re <= '0;
      r1_prod_im <= '0;
    end else if (w_en) begin
      r1_valid <= in_valid;
      if (in_valid) begin
        r1_sop     <= in_sop;
        r1_eop     <= in_eop;
        r1_prod_re <= w_prod_re;
        r1_prod_im <= w_prod_im;
        if (in_sop) r1_exp <= in_exp;
      end
    end
  end

  // Stage 2: shift, saturate, register outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      out_real  <= '0;
      out_imag  <= '0;
      out_exp   <= '0;
    end else if (w_en) begin
      out_valid <= r1_valid;
      if (r1_valid) begin
        out_sop  <= r1_sop;
        out_eop  <= r1_eop;
        out_real <= sat16(r1_prod_re);
        out_imag <= sat16(r1_prod_im);
        if (r1_sop) out_exp <= r1_exp;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fft_band_eq.sv
`default_nettype none
// ============================================================================
// Module   : tb_fft_band_eq
// Purpose  : Directed self-checking bench for fft_band_eq (defaults 4096/8/8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fft_band_eq;

  logic clk = 1'b0;
  logic reset_n;
  logic in_valid, in_ready, in_sop, in_eop;
  logic signed [15:0] in_real, in_imag;
  logic signed [5:0]  in_exp;
  logic out_valid, out_ready, out_sop, out_eop;
  logic signed [15:0] out_real, out_imag;
  logic signed [5:0]  out_exp;
  logic               gain_we;
  logic [2:0]         gain_addr;
  logic [7:0]         gain_wdata;
  logic               frame_err;

  fft_band_eq #(.POINTS(4096), .BANDS(8), .GAIN_W(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_sop(in_sop), .in_eop(in_eop),
    .in_real(in_real), .in_imag(in_imag), .in_exp(in_exp),
    .out_valid(out_valid), .out_ready(out_ready), .out_sop(out_sop), .out_eop(out_eop),
    .out_real(out_real), .out_imag(out_imag), .out_exp(out_exp),
    .gain_we(gain_we), .gain_addr(gain_addr), .gain_wdata(gain_wdata),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Backpressure pattern 1,0,0 repeating for a window after bp_start.
  bit bp_en = 1'b0;
  int bp_start = 0;
  initial out_ready = 1'b1;
  always @(posedge clk) begin
    #1;
    if (bp_en && (cyc - bp_start) < 60) out_ready = ((cyc - bp_start) % 3 == 0);
    else                                out_ready = 1'b1;
  end

  // Output monitor: captures the current frame by output bin index.
  logic signed [15:0] cap_re [4096];
  logic signed [15:0] cap_im [4096];
  logic signed [5:0]  cap_exp;
  int o_bin = 0, eop_idx = -1, t_out = 0, t_acc = 0;
  int sop_cnt = 0, beat_cnt = 0, stall_cnt = 0;
  bit stalled = 1'b0;
  logic [39:0] held;

  always @(negedge clk) begin
    if (reset_n) begin
      if (out_valid && !out_ready) check("in_ready_stall", in_ready, 0);
      if (stalled) check("hold", {out_real, out_imag, out_sop, out_eop, out_exp}, held);
      stalled = out_valid && !out_ready;
      held    = {out_real, out_imag, out_sop, out_eop, out_exp};
      if (stalled) stall_cnt++;
      if (out_valid && out_ready) begin
        o_bin = out_sop ? 0 : o_bin + 1;
        beat_cnt++;
        cap_re[o_bin % 4096] = out_real;
        cap_im[o_bin % 4096] = out_imag;
        if (out_sop) begin
          sop_cnt++;
          cap_exp = out_exp;
          t_out   = cyc;
        end
        if (out_eop) eop_idx = o_bin;
      end
    end else begin
      stalled = 1'b0;
    end
  end

  logic signed [15:0] tx_re [4096];
  logic signed [15:0] tx_im [4096];

  task automatic fill_default();
    for (int k = 0; k < 4096; k++) begin
      tx_re[k] = 16'(k);
      tx_im[k] = 16'(-k);
    end
  endtask

  task automatic write_gain(input int addr, input int val);
    gain_we = 1'b1; gain_addr = 3'(addr); gain_wdata = 8'(val);
    @(posedge clk); #1;
    gain_we = 1'b0;
  endtask

  task automatic send_frame(input int len, input int exp, input bit do_eop,
                            input int wr_bin, input int wr_addr, input int wr_val);
    bit acc;
    int waited;
    for (int k = 0; k < len; k++) begin
      in_valid = 1'b1; in_sop = (k == 0); in_eop = do_eop && (k == len - 1);
      in_real = tx_re[k]; in_imag = tx_im[k]; in_exp = 6'(exp);
      gain_we = (k == wr_bin); gain_addr = 3'(wr_addr); gain_wdata = 8'(wr_val);
      acc = 1'b0; waited = 0;
      while (!acc) begin
        @(negedge clk);
        acc = in_ready;
        if (acc && k == 0) t_acc = cyc;
        @(posedge clk); #1;
        gain_we = 1'b0;
        waited++;
        if (!acc && waited > 200) begin
          check("accept_timeout", 0, 1);
          in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
          return;
        end
      end
    end
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; gain_we = 1'b0;
  endtask

  task automatic drain();
    repeat (10) @(posedge clk);
    #1;
  endtask

  int s0, b0, st0;

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    in_real = '0; in_imag = '0; in_exp = '0;
    gain_we = 1'b0; gain_addr = '0; gain_wdata = '0;
    repeat (3) @(posedge clk); #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_out_real", out_real, 0);
    check("rst_out_exp", out_exp, 0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", in_ready, 1);

    // Unity gain, latency, exponent forwarding
    fill_default();
    tx_re[3] = 1000; tx_im[3] = -1000;
    s0 = sop_cnt; b0 = beat_cnt;
    send_frame(4096, -5, 1'b1, -1, 0, 0);
    drain();
    check("unity_re3", cap_re[3], 1000);
    check("unity_im3", cap_im[3], -1000);
    check("unity_re4095", cap_re[4095], 4095);
    check("unity_exp", cap_exp, -5);
    check("latency", t_out - t_acc, 2);
    check("unity_sops", sop_cnt - s0, 1);
    check("unity_beats", beat_cnt - b0, 4096);
    check("unity_eop_idx", eop_idx, 4095);
    check("unity_frame_err", frame_err, 0);

    // Saturation and truncation
    write_gain(0, 32);
    fill_default();
    tx_re[5] = 20000; tx_im[5] = -20000;
    send_frame(4096, 0, 1'b1, -1, 0, 0);
    drain();
    check("sat_re5", cap_re[5], 32767);
    check("sat_im5", cap_im[5], -32768);
    check("x2_re4", cap_re[4], 8);
    write_gain(0, 8);
    fill_default();
    tx_re[5] = -3; tx_im[5] = 3;
    send_frame(4096, 0, 1'b1, -1, 0, 0);
    drain();
    check("trunc_re5", cap_re[5], -2);
    check("trunc_im5", cap_im[5], 1);
    check("trunc_re7", cap_re[7], 3);
    check("trunc_im7", cap_im[7], -4);

    // Mirror mapping
    write_gain(0, 0);
    write_gain(7, 32);
    fill_default();
    tx_re[4095] = 100; tx_im[4095] = 0;
    tx_re[2048] = 100; tx_im[2048] = 0;
    tx_re[1792] = 100; tx_im[1792] = 0;
    send_frame(4096, 0, 1'b1, -1, 0, 0);
    drain();
    check("mirror_re4095", cap_re[4095], 0);
    check("mirror_im4095", cap_im[4095], 0);
    check("mirror_re2048", cap_re[2048], 200);
    check("mirror_re1792", cap_re[1792], 200);
    check("mirror_re1791", cap_re[1791], 1791);
    check("mirror_re2049", cap_re[2049], 4098);

    // Backpressure
    write_gain(0, 16);
    write_gain(7, 16);
    fill_default();
    b0 = beat_cnt; st0 = stall_cnt;
    bp_start = cyc; bp_en = 1'b1;
    send_frame(4096, 0, 1'b1, -1, 0, 0);
    bp_en = 1'b0;
    drain();
    for (int k = 0; k < 12; k++) begin
      check($sformatf("bp_re%0d", k), cap_re[k], k);
      check($sformatf("bp_im%0d", k), cap_im[k], -k);
    end
    check("bp_beats", beat_cnt - b0, 4096);
    check("bp_eop_idx", eop_idx, 4095);
    check("bp_stalls_seen", stall_cnt > st0, 1);

    // Gain shadowing: write gain[1]=48 while bin 300 is presented
    fill_default();
    send_frame(4096, 0, 1'b1, 300, 1, 48);
    drain();
    check("shadowA_re256", cap_re[256], 256);
    check("shadowA_re300", cap_re[300], 300);
    check("shadowA_re511", cap_re[511], 511);
    fill_default();
    tx_re[300] = 10; tx_im[300] = 0;
    send_frame(4096, 0, 1'b1, -1, 0, 0);
    drain();
    check("shadowB_re300", cap_re[300], 30);
    check("shadowB_re256", cap_re[256], 768);
    check("shadowB_re511", cap_re[511], 1533);

    // Framing errors
    write_gain(1, 16);
    fill_default();
    check("ferr_before", frame_err, 0);
    send_frame(101, 0, 1'b1, -1, 0, 0);
    check("ferr_short", frame_err, 1);
    drain();
    send_frame(4096, 0, 1'b1, -1, 0, 0);
    drain();
    check("ferr_sticky", frame_err, 1);
    send_frame(50, 0, 1'b0, -1, 0, 0);
    check("pre_reset_valid", out_valid, 1);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_frame_err", frame_err, 0);
    check("midrst_out_valid", out_valid, 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;

    // Single-beat frame: sop and eop together
    tx_re[0] = 16; tx_im[0] = -16;
    send_frame(1, 3, 1'b1, -1, 0, 0);
    check("sopeop_ferr", frame_err, 1);
    drain();
    check("sopeop_eop_idx", eop_idx, 0);
    check("sopeop_exp", cap_exp, 3);
    check("sopeop_re0", cap_re[0], 16);
    check("sopeop_im0", cap_im[0], -16);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
